broadsync_frame_ctrl: RTL and testbench
=======================================

BROADSYNC_FRAME_CTRL -- requirements
Module: broadsync_frame_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- PERIOD_WIDTH, 32, frame-interval counter width.
- TIMEOUT_WIDTH, 24, frame-timeout counter width.
- NS_WIDTH, 30, nanosecond field width.
- S_WIDTH, 48, seconds field width.
- LOCK_WIDTH, 4, good-frame counter width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- ptp_clk, in, 1, sole clock.
- ptp_reset_n, in, 1, reset, asynchronous, active-low.
- cfg_enable, in, 1, run frame scheduling.
- cfg_period, in, PERIOD_WIDTH, ptp_clk cycles between frame_en pulses.
- cfg_timeout, in, TIMEOUT_WIDTH, max cycles from frame_en to frame_done; 0 = period-bounded only.
- cfg_lock_count, in, LOCK_WIDTH, consecutive good frames needed for lock; 0 = lock never asserted.
- frame_en, out, 1, one-cycle frame start pulse to the broadsync datapath.
- frame_done, in, 1, datapath frame-complete pulse.
- frame_error, in, 1, error qualifier, valid with frame_done.
- lock_value_out, in, 1, received lock bit, valid with frame_done.
- time_value_out, in, S_WIDTH+NS_WIDTH+2, received time, valid with frame_done.
- captured_time, out, S_WIDTH+NS_WIDTH+2, last good received time.
- capture_valid, out, 1, one-cycle pulse when captured_time updates.
- locked, out, 1, lock status.
- busy, out, 1, frame outstanding (ISSUE or WAIT_DONE).
- err_timeout_cnt, out, 16, saturating timeout/overrun count.
- err_frame_cnt, out, 16, saturating frame_error count.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, WAIT_PERIOD.
REQ-004 IDLE: when cfg_enable=1, SHALL go to ISSUE next cycle; otherwise SHALL stay.
REQ-005 ISSUE (1 cycle): SHALL drive frame_en=1, load period counter with max(cfg_period,2)-1, clear timeout counter, and go to WAIT_DONE.
REQ-006 The period counter SHALL decrement every cycle outside IDLE, hold at 0, and not reload except in ISSUE.
REQ-007 WAIT_DONE: the timeout counter SHALL increment each cycle; frame_done SHALL have priority over timeout and overrun in the same cycle.
REQ-008 WAIT_DONE with frame_done=1 and frame_error=0 SHALL:
- register time_value_out into captured_time;
- pulse capture_valid in the following cycle;
- if lock_value_out=1, increment the good counter (saturating at cfg_lock_count), else clear it;
- go to WAIT_PERIOD.
REQ-009 WAIT_DONE with frame_done=1 and frame_error=1 SHALL increment err_frame_cnt, clear the good counter, leave captured_time unchanged, and go to WAIT_PERIOD.
REQ-010 WAIT_DONE timeout: cfg_timeout!=0 with timeout counter = cfg_timeout and no frame_done SHALL increment err_timeout_cnt, clear the good counter, and go to WAIT_PERIOD.
REQ-011 WAIT_DONE overrun: period counter = 0 with no frame_done SHALL increment err_timeout_cnt, clear the good counter, and go directly to ISSUE if cfg_enable=1, else to IDLE.
REQ-012 WAIT_PERIOD: at period counter = 0, SHALL go to ISSUE if cfg_enable=1, else to IDLE.
REQ-013 The frame_en period SHALL be exactly max(cfg_period,2) cycles while enabled and frames complete in time.
REQ-014 frame_done outside WAIT_DONE SHALL be ignored, with no counter or capture effect.
REQ-015 Deassertion of cfg_enable SHALL NOT abort an outstanding frame; it takes effect at the next ISSUE decision point.
REQ-016 locked SHALL be 1 iff cfg_lock_count!=0, good counter >= cfg_lock_count, and cfg_enable=1; it SHALL update registered, one cycle after the qualifying event.
REQ-017 Error counters SHALL saturate at 16'hFFFF and clear only on reset.
REQ-018 cfg_* SHALL be sampled only in ISSUE (cfg_period) and in WAIT_DONE (cfg_timeout, cfg_lock_count); mid-frame changes apply from those points.

Reset
REQ-019 On ptp_reset_n=0, SHALL set state=IDLE and force frame_en, capture_valid, locked, busy, captured_time, all counters and err counts to 0.
REQ-020 Reset assertion mid-frame SHALL drop frame_en and busy immediately; after release, a new frame SHALL start only via IDLE.

Structure
REQ-021 State encoding and the error-counter width (16) SHALL live in shared package broadsync_pkg.
REQ-022 Single module; the saturating counter MAY be a sub-module named broadsync_sat_cnt, used for both error counters.

Verification
REQ-023 cfg_period=10, cfg_timeout=0, frame_done 4 cycles after each frame_en -> frame_en every 10 cycles; busy high 5 cycles per frame; no errors.
REQ-024 Good frame, time_value_out=0x0000_1234_5678_9ABC_DEF0 (truncated to width) with frame_done -> captured_time equals it and capture_valid pulses once, the cycle after frame_done.
REQ-025 cfg_lock_count=3, three good frames with lock_value_out=1 -> locked rises after the 3rd; one frame_error -> err_frame_cnt=1, locked falls next cycle.
REQ-026 cfg_timeout=5, cfg_period=20, no frame_done -> err_timeout_cnt increments by 1 per frame; next frame_en 20 cycles after the previous one.
REQ-027 cfg_timeout=0, cfg_period=8, no frame_done -> overrun; err_timeout_cnt +1 per frame; frame_en every 8 cycles; frame_done coincident with period=0 -> treated as done, no error.
REQ-028 Disable during WAIT_DONE, then frame_done -> capture occurs, FSM goes to IDLE, no further frame_en; ptp_reset_n pulse mid-frame -> all outputs 0 next edge.

Source files
------------

// File: rtl/broadsync_pkg.sv
// Shared definitions for the broadsync frame controller: FSM encoding and error counter width.
package broadsync_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_DONE   = 2'd2,
        ST_WAIT_PERIOD = 2'd3
    } frame_state_e;

endpackage

// File: rtl/broadsync_sat_cnt.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module broadsync_sat_cnt
    import broadsync_pkg::*;
#(
    parameter int W = ERR_CNT_W
) (
    input  logic         ptp_clk,
    input  logic         ptp_reset_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge ptp_clk or negedge ptp_reset_n) begin
        if (!ptp_reset_n)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/broadsync_frame_ctrl.sv
// Broadsync frame scheduler: issues periodic frame_en pulses, supervises completion,
// captures good received time and tracks lock / error statistics.
module broadsync_frame_ctrl
    import broadsync_pkg::*;
#(
    parameter int PERIOD_WIDTH  = 32,
    parameter int TIMEOUT_WIDTH = 24,
    parameter int NS_WIDTH      = 30,
    parameter int S_WIDTH       = 48,
    parameter int LOCK_WIDTH    = 4
) (
    input  logic                            ptp_clk,
    input  logic                            ptp_reset_n,
    input  logic                            cfg_enable,
    input  logic [PERIOD_WIDTH-1:0]         cfg_period,
    input  logic [TIMEOUT_WIDTH-1:0]        cfg_timeout,
    input  logic [LOCK_WIDTH-1:0]           cfg_lock_count,
    output logic                            frame_en,
    input  logic                            frame_done,
    input  logic                            frame_error,
    input  logic                            lock_value_out,
    input  logic [S_WIDTH+NS_WIDTH+1:0]     time_value_out,
    output logic [S_WIDTH+NS_WIDTH+1:0]     captured_time,
    output logic                            capture_valid,
    output logic                            locked,
    output logic                            busy,
    output logic [ERR_CNT_W-1:0]            err_timeout_cnt,
    output logic [ERR_CNT_W-1:0]            err_frame_cnt
);

    frame_state_e              state, state_nxt;
    logic [PERIOD_WIDTH-1:0]   period_cnt, period_load;
    logic [TIMEOUT_WIDTH-1:0]  tmo_cnt;
    logic [LOCK_WIDTH-1:0]     good_cnt, good_nxt, lock_cfg, lock_cfg_nxt;
    logic                      in_wait, period_zero, tmo_hit;
    logic                      done_ok, done_err, frame_miss;

    assign in_wait     = (state == ST_WAIT_DONE);
    assign period_zero = (period_cnt == '0);
    assign tmo_hit     = (cfg_timeout != '0) && (tmo_cnt == cfg_timeout);
    assign done_ok     = in_wait && frame_done && !frame_error;
    assign done_err    = in_wait && frame_done && frame_error;
    assign frame_miss  = in_wait && !frame_done && (period_zero || tmo_hit);

    assign period_load = (cfg_period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1) : cfg_period - 1'b1;

    always_comb begin
        state_nxt = state;
        frame_en  = (state == ST_ISSUE);
        busy      = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
        case (state)
            ST_IDLE:        if (cfg_enable) state_nxt = ST_ISSUE;
            ST_ISSUE:       state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // Overrun wins over a simultaneous timeout: the frame slot is already used up.
                if (frame_done || (tmo_hit && !period_zero))
                    state_nxt = ST_WAIT_PERIOD;
                else if (period_zero)
                    state_nxt = cfg_enable ? ST_ISSUE : ST_IDLE;
            end
            ST_WAIT_PERIOD: if (period_zero) state_nxt = cfg_enable ? ST_ISSUE : ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        good_nxt = good_cnt;
        if (done_ok) begin
            if (!lock_value_out)
                good_nxt = '0;
            else if (good_cnt >= cfg_lock_count)
                good_nxt = cfg_lock_count;
            else
                good_nxt = good_cnt + 1'b1;
        end else if (done_err || frame_miss) begin
            good_nxt = '0;
        end
    end

    assign lock_cfg_nxt = in_wait ? cfg_lock_count : lock_cfg;

    always_ff @(posedge ptp_clk or negedge ptp_reset_n) begin
        if (!ptp_reset_n) begin
            state         <= ST_IDLE;
            period_cnt    <= '0;
            tmo_cnt       <= '0;
            good_cnt      <= '0;
            lock_cfg      <= '0;
            locked        <= 1'b0;
            capture_valid <= 1'b0;
            captured_time <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            lock_cfg <= lock_cfg_nxt;
            locked   <= (lock_cfg_nxt != '0) && (good_nxt >= lock_cfg_nxt) && cfg_enable;
            // The ISSUE cycle is itself the first decrement, so the count hits 0
            // in the last cycle of the frame slot.
            if (state == ST_ISSUE)
                period_cnt <= period_load - 1'b1;
            else if ((state != ST_IDLE) && !period_zero)
                period_cnt <= period_cnt - 1'b1;
            if (state == ST_ISSUE)
                tmo_cnt <= '0;
            else if (in_wait)
                tmo_cnt <= tmo_cnt + 1'b1;
            capture_valid <= done_ok;
            if (done_ok)
                captured_time <= time_value_out;
        end
    end

    broadsync_sat_cnt #(.W(ERR_CNT_W)) u_tmo_err (
        .ptp_clk     (ptp_clk),
        .ptp_reset_n (ptp_reset_n),
        .inc         (frame_miss),
        .cnt         (err_timeout_cnt)
    );

    broadsync_sat_cnt #(.W(ERR_CNT_W)) u_frm_err (
        .ptp_clk     (ptp_clk),
        .ptp_reset_n (ptp_reset_n),
        .inc         (done_err),
        .cnt         (err_frame_cnt)
    );

endmodule

// File: tb/tb_broadsync_frame_ctrl.sv
// Randomized scoreboard bench for broadsync_frame_ctrl, with a frame-level reference model.
module tb_broadsync_frame_ctrl;

    localparam int TW = 80;
    localparam int K_GOOD = 0, K_ERR = 1, K_NONE = 2;

    logic           ptp_clk = 1'b0;
    logic           ptp_reset_n;
    logic           cfg_enable;
    logic [31:0]    cfg_period;
    logic [23:0]    cfg_timeout;
    logic [3:0]     cfg_lock_count;
    logic           frame_en, frame_done, frame_error, lock_value_out;
    logic [TW-1:0]  time_value_out, captured_time;
    logic           capture_valid, locked, busy;
    logic [15:0]    err_timeout_cnt, err_frame_cnt;
    logic           sc_inc;
    logic [2:0]     sc_cnt;

    broadsync_frame_ctrl dut (
        .ptp_clk(ptp_clk), .ptp_reset_n(ptp_reset_n), .cfg_enable(cfg_enable),
        .cfg_period(cfg_period), .cfg_timeout(cfg_timeout), .cfg_lock_count(cfg_lock_count),
        .frame_en(frame_en), .frame_done(frame_done), .frame_error(frame_error),
        .lock_value_out(lock_value_out), .time_value_out(time_value_out),
        .captured_time(captured_time), .capture_valid(capture_valid), .locked(locked),
        .busy(busy), .err_timeout_cnt(err_timeout_cnt), .err_frame_cnt(err_frame_cnt)
    );

    broadsync_sat_cnt #(.W(3)) u_sc (
        .ptp_clk(ptp_clk), .ptp_reset_n(ptp_reset_n), .inc(sc_inc), .cnt(sc_cnt)
    );

    always #5 ptp_clk = ~ptp_clk;

    int cyc = 0;
    always @(posedge ptp_clk) cyc <= cyc + 1;

    typedef struct { int cyc; int blen; } fe_t;
    typedef struct { int cyc; logic [TW-1:0] tv; } cap_t;
    typedef struct { int cyc; int tcnt; int fcnt; bit lk; logic [TW-1:0] ct; } st_t;

    fe_t  fe_q[$];
    cap_t cap_q[$];
    st_t  st_q[$];

    int n_cmp = 0, n_err = 0;
    bit mon_en = 0;

    // reference model state
    int m_tcnt = 0, m_fcnt = 0, m_good = 0;
    logic [TW-1:0] m_ct = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge ptp_clk);
            #1;
        end
    endtask

    function automatic logic [TW-1:0] rnd_time();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[TW-1:0];
    endfunction

    // monitor: compares DUT outputs against queued expectations
    bit meas = 0;
    int bcnt = 0, blen = 0;
    always @(negedge ptp_clk) begin
        if (!(mon_en && ptp_reset_n)) begin
            meas = 0;
        end else begin
            if (meas && (frame_en || !busy)) begin
                chk("busy_len", 128'(bcnt), 128'(blen));
                meas = 0;
            end
            if (fe_q.size() != 0 && fe_q[0].cyc == cyc) begin
                fe_t e;
                e = fe_q.pop_front();
                chk("frame_en", 128'(frame_en), 128'(1));
                meas = 1; blen = e.blen; bcnt = 0;
            end else if (frame_en) begin
                chk("frame_en_spurious", 128'(frame_en), 128'(0));
            end
            if (meas && busy) bcnt++;

            if (cap_q.size() != 0 && cap_q[0].cyc == cyc) begin
                cap_t c;
                c = cap_q.pop_front();
                chk("capture_valid", 128'(capture_valid), 128'(1));
                chk("capture_time", 128'(captured_time), 128'(c.tv));
            end else if (capture_valid) begin
                chk("capture_valid_spurious", 128'(capture_valid), 128'(0));
            end

            if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
                st_t s;
                s = st_q.pop_front();
                chk("err_timeout_cnt", 128'(err_timeout_cnt), 128'(s.tcnt));
                chk("err_frame_cnt", 128'(err_frame_cnt), 128'(s.fcnt));
                chk("locked", 128'(locked), 128'(s.lk));
                chk("captured_time_hold", 128'(captured_time), 128'(s.ct));
            end
        end
    end

    // mode: 0 random, 1 good/lock script (4th frame errors), 2 no frame_done, 3 done at last slot cycle
    task automatic run_phase(input int per, input int tmo, input int lk, input int mode, input int nfr);
        int p, t, d, dmax, kind, e, tn;
        bit lbit, last;
        logic [TW-1:0] tv;
        p = (per < 2) ? 2 : per;
        cfg_period = 32'(per); cfg_timeout = 24'(tmo); cfg_lock_count = 4'(lk);
        wait_to(cyc + 1);
        cfg_enable = 1'b1;
        t = cyc + 1;
        for (int f = 0; f < nfr; f++) begin
            last = (f == nfr - 1);
            dmax = p - 1;
            if (tmo != 0 && tmo + 1 < dmax) dmax = tmo + 1;
            d = $urandom_range(1, dmax);
            lbit = ($urandom_range(0, 3) != 0);
            tv = rnd_time();
            case (mode)
                1: begin
                    kind = (f == 3) ? K_ERR : K_GOOD; d = 4; lbit = 1'b1;
                    if (f == 0) tv = 80'h0000_1234_5678_9ABC_DEF0;
                end
                2: kind = K_NONE;
                3: begin kind = K_GOOD; d = p - 1; end
                default: begin
                    kind = $urandom_range(0, 4);
                    kind = (kind <= 2) ? K_GOOD : (kind == 3) ? K_ERR : K_NONE;
                end
            endcase
            if (kind == K_NONE) begin
                e = (tmo != 0 && tmo + 1 < p - 1) ? t + tmo + 1 : t + p - 1;
                tn = t + p;
                if (m_tcnt < 65535) m_tcnt++;
                m_good = 0;
            end else begin
                e = t + d;
                tn = (d == p - 1) ? t + p + 1 : t + p;
                if (kind == K_ERR) begin
                    if (m_fcnt < 65535) m_fcnt++;
                    m_good = 0;
                end else begin
                    m_ct = tv;
                    m_good = lbit ? ((m_good + 1 < lk) ? m_good + 1 : lk) : 0;
                    cap_q.push_back('{e + 1, tv});
                end
            end
            st_q.push_back('{e + 1, m_tcnt, m_fcnt, (lk != 0 && m_good >= lk && !last), m_ct});
            fe_q.push_back('{t, e - t + 1});

            wait_to(t + 1);
            if (last) cfg_enable = 1'b0;
            if (kind != K_NONE) begin
                wait_to(e);
                frame_done = 1'b1; frame_error = (kind == K_ERR);
                lock_value_out = lbit; time_value_out = tv;
                wait_to(e + 1);
                if ($urandom_range(0, 2) == 0) begin
                    frame_error = 1'($urandom()); lock_value_out = 1'($urandom());
                    time_value_out = rnd_time();
                    wait_to(e + 2);
                end
                frame_done = 1'b0;
            end
            t = tn;
        end
        wait_to(t);
        frame_done = 1'b1; frame_error = 1'($urandom()); time_value_out = rnd_time();
        wait_to(t + 1);
        frame_done = 1'b0;
        wait_to(t + 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r, tmo;
        ptp_reset_n = 1'b0; cfg_enable = 1'b0; cfg_period = 32'd10; cfg_timeout = '0;
        cfg_lock_count = '0; frame_done = 1'b0; frame_error = 1'b0; lock_value_out = 1'b0;
        time_value_out = '0; sc_inc = 1'b0;
        repeat (3) @(posedge ptp_clk);
        #1;
        chk("rst_frame_en", 128'(frame_en), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_capture_valid", 128'(capture_valid), 128'(0));
        chk("rst_locked", 128'(locked), 128'(0));
        chk("rst_captured_time", 128'(captured_time), 128'(0));
        chk("rst_err_timeout", 128'(err_timeout_cnt), 128'(0));
        chk("rst_err_frame", 128'(err_frame_cnt), 128'(0));
        ptp_reset_n = 1'b1;
        mon_en = 1'b1;
        wait_to(cyc + 2);

        run_phase(10, 0, 3, 1, 5);
        run_phase(20, 5, 2, 2, 3);
        run_phase(8, 0, 2, 2, 3);
        run_phase(8, 0, 1, 3, 3);
        for (int i = 0; i < 14; i++) begin
            tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 8);
            run_phase($urandom_range(0, 12), tmo, $urandom_range(0, 4), 0, $urandom_range(3, 7));
        end
        wait_to(cyc + 2);
        chk("fe_q_drained", 128'(fe_q.size()), 128'(0));
        chk("cap_q_drained", 128'(cap_q.size()), 128'(0));
        chk("st_q_drained", 128'(st_q.size()), 128'(0));

        // asynchronous reset in the middle of a frame
        mon_en = 1'b0;
        cfg_period = 32'd10; cfg_timeout = '0; cfg_lock_count = 4'd1;
        wait_to(cyc + 1);
        cfg_enable = 1'b1;
        c = cyc;
        wait_to(c + 3);
        #2;
        chk("pre_reset_busy", 128'(busy), 128'(1));
        ptp_reset_n = 1'b0;
        #1;
        chk("mid_rst_frame_en", 128'(frame_en), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_capture_valid", 128'(capture_valid), 128'(0));
        chk("mid_rst_locked", 128'(locked), 128'(0));
        chk("mid_rst_captured_time", 128'(captured_time), 128'(0));
        chk("mid_rst_err_timeout", 128'(err_timeout_cnt), 128'(0));
        chk("mid_rst_err_frame", 128'(err_frame_cnt), 128'(0));
        wait_to(cyc + 2);
        ptp_reset_n = 1'b1;
        r = cyc;
        #3;
        chk("post_rst_idle_frame_en", 128'(frame_en), 128'(0));
        chk("post_rst_idle_busy", 128'(busy), 128'(0));
        wait_to(r + 1);
        #3;
        chk("post_rst_frame_en", 128'(frame_en), 128'(1));
        cfg_enable = 1'b0;

        // saturating counter on its own, narrow width
        wait_to(cyc + 1);
        sc_inc = 1'b1;
        c = cyc;
        wait_to(c + 5);
        chk("sat_cnt_count", 128'(sc_cnt), 128'(5));
        wait_to(c + 12);
        chk("sat_cnt_saturate", 128'(sc_cnt), 128'(7));
        sc_inc = 1'b0;
        wait_to(cyc + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
